// File: rtl/mau_pkg.sv
// mau_pkg: shared types and width helpers for the MAU stream core.
//   op_e       - decoded opcodes (values 6..15 are illegal and not enumerated)
//   tx_state_e - read-lane serialiser state
//   rx_beats() - lane beats in one instruction frame (five W-bit fields)
//   res_width()- ALU result width, wide enough for a DOT2 sum plus headroom
//   tx_beats() - lane beats needed to send one result, MS end zero-padded
package mau_pkg;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    MUL  = 4'd2,
    DOT2 = 4'd3,
    ACC  = 4'd4,
    CLR  = 4'd5
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

  function automatic int rx_beats(input int w, input int lane);
    return (5 * w) / lane;
  endfunction

  function automatic int res_width(input int w);
    return 2 * w + 2;
  endfunction

  function automatic int tx_beats(input int w, input int lane);
    return (2 * w + 2 + lane - 1) / lane;
  endfunction

endpackage

// File: rtl/mau_res_fifo.sv
// mau_res_fifo: small result queue with registered occupancy count.
//   clk, rst   - clock, asynchronous active-high reset (empties the queue)
//   push       - write push_data; accepted when not full, or when full and a
//                pop happens on the same edge
//   pop        - drop the head entry; ignored when empty
//   head       - current head entry (valid while empty is low)
//   full/empty - occupancy flags derived from count
//   count      - number of entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module mau_res_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign do_pop  = pop & ~empty;
  // A pop on the same edge frees the slot the push needs.
  assign do_push = push & (~full | do_pop);

  // The head is read combinationally: the serialiser may load it on the
  // first read event after a push, so a read register would need extra
  // hand-shaking for a four-entry store.
  assign head = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/mau_stream_core.sv
// mau_stream_core: serial-lane MAU. Deserialises five-field instruction
// frames from the write lane, executes them on a W-bit ALU with an
// accumulator, queues results, and serialises them MS beat first on the
// read lane.
//   clk, rst         - system clock, asynchronous active-high reset
//   spi_clk          - beat clock (asynchronous, synchronised internally)
//   spi_w / mosi     - write enable and write-lane data
//   spi_r / miso     - read enable and registered read-lane data
//   carry_out        - carry/flag of the result being sent
//   busy             - frame partially received or result partially sent
//   res_count        - results waiting in the queue
//   ovf_err          - sticky: a complete frame was dropped on a full queue
module mau_stream_core
  import mau_pkg::*;
#(
  parameter int W         = 8,
  parameter int LANE      = 4,
  parameter int RES_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           spi_clk,
  input  logic                           spi_w,
  input  logic                           spi_r,
  input  logic [LANE-1:0]                mosi,
  output logic [LANE-1:0]                miso,
  output logic                           carry_out,
  output logic                           busy,
  output logic [$clog2(RES_DEPTH+1)-1:0] res_count,
  output logic                           ovf_err
);

  localparam int RX_BEATS = rx_beats(W, LANE);
  localparam int RW       = res_width(W);
  localparam int TX_BEATS = tx_beats(W, LANE);
  localparam int TXW      = TX_BEATS * LANE;
  localparam int FRAME_W  = 5 * W;
  localparam int RXC_W    = $clog2(RX_BEATS);
  localparam int TXI_W    = $clog2(TX_BEATS + 1);

  // ---------------- input synchronisers and rise detect ----------------
  logic [1:0]      sclk_sync_reg;
  logic [1:0]      w_sync_reg;
  logic [1:0]      r_sync_reg;
  logic [LANE-1:0] mosi_meta_reg;
  logic [LANE-1:0] mosi_sync_reg;
  logic            sclk_prev_reg;
  logic            rise;
  logic            rx_ev;
  logic            tx_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_reg <= '0;
      w_sync_reg    <= '0;
      r_sync_reg    <= '0;
      mosi_meta_reg <= '0;
      mosi_sync_reg <= '0;
      sclk_prev_reg <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[0], spi_clk};
      w_sync_reg    <= {w_sync_reg[0], spi_w};
      r_sync_reg    <= {r_sync_reg[0], spi_r};
      mosi_meta_reg <= mosi;
      mosi_sync_reg <= mosi_meta_reg;
      sclk_prev_reg <= sclk_sync_reg[1];
    end
  end

  assign rise  = sclk_sync_reg[1] & ~sclk_prev_reg;
  assign rx_ev = rise & w_sync_reg[1];
  assign tx_ev = rise & r_sync_reg[1];

  // ---------------- RX deserialiser ----------------
  logic [FRAME_W-1:0] frame_reg;
  logic [RXC_W-1:0]   rx_cnt_reg;
  logic               exec_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_reg  <= '0;
      rx_cnt_reg <= '0;
      exec_reg   <= 1'b0;
    end else begin
      exec_reg <= 1'b0;
      if (rx_ev) begin
        frame_reg <= {frame_reg[FRAME_W-LANE-1:0], mosi_sync_reg};
        if (rx_cnt_reg == RXC_W'(RX_BEATS - 1)) begin
          rx_cnt_reg <= '0;
          exec_reg   <= 1'b1;
        end else begin
          rx_cnt_reg <= rx_cnt_reg + RXC_W'(1);
        end
      end
    end
  end

  // Field layout after the last shift: op is oldest, b2 youngest.
  logic [3:0]   op_nib;
  logic [W-1:0] a1;
  logic [W-1:0] a2;
  logic [W-1:0] b1;
  logic [W-1:0] b2;

  assign op_nib = frame_reg[4*W +: 4];
  assign a1     = frame_reg[3*W +: W];
  assign a2     = frame_reg[2*W +: W];
  assign b1     = frame_reg[W +: W];
  assign b2     = frame_reg[0 +: W];

  generate
    if (W > 4) begin : g_op_hi
      // Upper opcode bits are carried in the frame but never decoded.
      logic unused_op_hi;
      assign unused_op_hi = ^frame_reg[FRAME_W-1:4*W+4];
    end
  endgenerate

  // ---------------- ALU ----------------
  logic [RW-1:0]  acc_reg;
  logic [W:0]     sum_add;
  logic [W-1:0]   diff;
  logic [2*W-1:0] prod1;
  logic [2*W-1:0] prod2;
  logic [2*W:0]   dot;
  logic [RW:0]    acc_sum;
  logic [RW-1:0]  alu_res;
  logic           alu_carry;
  logic [RW-1:0]  acc_next;
  logic           acc_wr;

  assign sum_add = (W+1)'(a1) + (W+1)'(b1);
  assign diff    = a1 - b1;
  assign prod1   = (2*W)'(a1) * (2*W)'(b1);
  assign prod2   = (2*W)'(a2) * (2*W)'(b2);
  assign dot     = (2*W+1)'(prod1) + (2*W+1)'(prod2);
  // One extra bit exposes the accumulator wrap as the ACC carry.
  assign acc_sum = {1'b0, acc_reg} + (RW+1)'(prod1);

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    acc_next  = acc_reg;
    acc_wr    = 1'b0;
    case (op_nib)
      ADD: begin
        alu_res   = RW'(sum_add);
        alu_carry = sum_add[W];
      end
      SUB: begin
        alu_res   = RW'(diff);
        alu_carry = (a1 < b1);
      end
      MUL: begin
        alu_res = RW'(prod1);
      end
      DOT2: begin
        alu_res   = RW'(dot);
        alu_carry = dot[2*W];
      end
      ACC: begin
        acc_next  = acc_sum[RW-1:0];
        acc_wr    = 1'b1;
        alu_res   = acc_sum[RW-1:0];
        alu_carry = acc_sum[RW];
      end
      CLR: begin
        acc_next = '0;
        acc_wr   = 1'b1;
      end
      default: begin
        alu_carry = 1'b1;
      end
    endcase
  end

  // ---------------- result queue ----------------
  logic [RW:0]   fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_pop;
  logic          push_ok;

  mau_res_fifo #(
    .WIDTH (RW + 1),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (exec_reg),
    .push_data ({alu_carry, alu_res}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (res_count)
  );

  // Same acceptance rule as the queue: a pop on this edge makes room.
  assign push_ok = exec_reg & (~fifo_full | fifo_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_reg <= '0;
      ovf_err <= 1'b0;
    end else if (exec_reg) begin
      if (push_ok) begin
        if (acc_wr) begin
          acc_reg <= acc_next;
        end
      end else begin
        ovf_err <= 1'b1;
      end
    end
  end

  // ---------------- TX serialiser ----------------
  // Beat table for the head result, beat 0 = MS. The extra trailing zero
  // entry is what miso shows on the pop event.
  logic [TXW-1:0]  tx_padded;
  logic [LANE-1:0] tx_beat [TX_BEATS+1];

  assign tx_padded = TXW'(fifo_head[RW-1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < TX_BEATS; gi++) begin : g_tx_beat
      assign tx_beat[gi] = tx_padded[TXW-1-gi*LANE -: LANE];
    end
  endgenerate
  assign tx_beat[TX_BEATS] = '0;

  tx_state_e       tx_state_reg;
  tx_state_e       tx_state_next;
  logic [TXI_W-1:0] tx_idx_reg;
  logic [TXI_W-1:0] tx_idx_next;
  logic [LANE-1:0]  miso_next;
  logic             carry_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_reg <= IDLE;
      tx_idx_reg   <= '0;
      miso         <= '0;
      carry_out    <= 1'b0;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_idx_reg   <= tx_idx_next;
      miso         <= miso_next;
      carry_out    <= carry_next;
    end
  end

  always_comb begin
    tx_state_next = tx_state_reg;
    tx_idx_next   = tx_idx_reg;
    miso_next     = miso;
    carry_next    = carry_out;
    fifo_pop      = 1'b0;
    if (tx_ev) begin
      case (tx_state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            miso_next     = tx_beat[0];
            carry_next    = fifo_head[RW];
            tx_state_next = SEND;
            tx_idx_next   = TXI_W'(1);
          end
        end
        SEND: begin
          // Index TX_BEATS selects the zero entry: that event pops.
          miso_next = tx_beat[tx_idx_reg];
          if (tx_idx_reg == TXI_W'(TX_BEATS)) begin
            fifo_pop      = 1'b1;
            carry_next    = 1'b0;
            tx_state_next = IDLE;
            tx_idx_next   = '0;
          end else begin
            tx_idx_next = tx_idx_reg + TXI_W'(1);
          end
        end
        default: begin
          tx_state_next = IDLE;
          tx_idx_next   = '0;
        end
      endcase
    end
  end

  assign busy = (rx_cnt_reg != '0) | (tx_state_reg == SEND);

endmodule

// File: tb/tb_mau_stream_core.sv
// Randomised scoreboard bench for mau_stream_core (W=8, LANE=4, depth 4).
module tb_mau_stream_core;

  localparam int W         = 8;
  localparam int LANE      = 4;
  localparam int RES_DEPTH = 4;
  localparam int RW        = 2 * W + 2;
  localparam int TXB       = (RW + LANE - 1) / LANE;
  localparam int FB        = W / LANE;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            spi_clk = 1'b0;
  logic            spi_w = 1'b0;
  logic            spi_r = 1'b0;
  logic [LANE-1:0] mosi = '0;
  logic [LANE-1:0] miso;
  logic            carry_out;
  logic            busy;
  logic [2:0]      res_count;
  logic            ovf_err;

  always #5 clk = ~clk;

  mau_stream_core #(.W(W), .LANE(LANE), .RES_DEPTH(RES_DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .spi_clk   (spi_clk),
    .spi_w     (spi_w),
    .spi_r     (spi_r),
    .mosi      (mosi),
    .miso      (miso),
    .carry_out (carry_out),
    .busy      (busy),
    .res_count (res_count),
    .ovf_err   (ovf_err)
  );

  typedef struct {
    longint res;
    bit     c;
  } exp_t;

  exp_t   exp_q[$];
  longint acc_m = 0;
  bit     ovf_m = 0;
  int     mon_idx = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  event   read_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // One lane beat: data/enables settle, then a spi_clk pulse long enough
  // for the synchronisers and the execute/pop edge to complete.
  task automatic beat(input bit w, input bit r, input logic [LANE-1:0] d);
    @(negedge clk);
    mosi = d; spi_w = w; spi_r = r;
    repeat (2) @(negedge clk);
    spi_clk = 1'b1;
    repeat (4) @(negedge clk);
    spi_clk = 1'b0;
    repeat (3) @(negedge clk);
    spi_w = 1'b0; spi_r = 1'b0;
    if (r) -> read_ev;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    mon_idx = 0; acc_m = 0; ovf_m = 0;
    check("rst_miso", 32'(miso), 0);
    check("rst_carry", 32'(carry_out), 0);
    check("rst_count", 32'(res_count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ovf", 32'(ovf_err), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send_frame(input int op, input int a1, input int a2, input int b1, input int b2);
    logic [W-1:0] fld [5];
    logic [W-1:0] tmp;
    longint r, s;
    bit c;
    longint new_acc;
    fld[0] = W'(op); fld[1] = W'(a1); fld[2] = W'(a2); fld[3] = W'(b1); fld[4] = W'(b2);
    for (int fi = 0; fi < 5; fi++)
      for (int k = 0; k < FB; k++) begin
        tmp = fld[fi] >> ((FB - 1 - k) * LANE);
        beat(1'b1, 1'b0, tmp[LANE-1:0]);
      end
    // Reference behaviour from the operation definitions.
    new_acc = acc_m; r = 0; c = 0;
    case (op & 15)
      0: begin r = a1 + b1; c = ((r >> W) & 1) != 0; end
      1: begin r = (a1 - b1 + (64'd1 << W)) % (64'd1 << W); c = (a1 < b1); end
      2: begin r = a1 * b1; end
      3: begin r = a1 * b1 + a2 * b2; c = ((r >> (2 * W)) & 1) != 0; end
      4: begin
        s = acc_m + a1 * b1;
        c = (s >= (64'd1 << RW));
        new_acc = s % (64'd1 << RW);
        r = new_acc;
      end
      5: begin new_acc = 0; end
      default: begin c = 1; end
    endcase
    if (exp_q.size() == RES_DEPTH) begin
      ovf_m = 1;
    end else begin
      exp_q.push_back('{r, c});
      acc_m = new_acc;
    end
    @(negedge clk);
    check("frame_count", 32'(res_count), 32'(exp_q.size()));
    check("frame_ovf", 32'(ovf_err), 32'(ovf_m));
  endtask

  task automatic read_result();
    bit had;
    had = (exp_q.size() > 0);
    for (int i = 0; i <= TXB; i++) begin
      beat(1'b0, 1'b1, '0);
      if (i == 0) check("busy_send", 32'(busy), 32'(had));
    end
    @(negedge clk);
    check("read_count", 32'(res_count), 32'(exp_q.size()));
    check("read_busy", 32'(busy), 0);
    check("read_ovf", 32'(ovf_err), 32'(ovf_m));
  endtask

  // Monitor: one comparison set per read event against the scoreboard head.
  initial begin
    longint eb;
    forever begin
      @(read_ev);
      if (mon_idx == 0) begin
        if (exp_q.size() == 0) begin
          check("idle_miso", 32'(miso), 0);
        end else begin
          eb = (exp_q[0].res >> ((TXB - 1) * LANE)) & ((64'd1 << LANE) - 1);
          check("beat0", 32'(miso), 32'(eb));
          check("carry0", 32'(carry_out), 32'(exp_q[0].c));
          mon_idx = 1;
        end
      end else if (mon_idx < TXB) begin
        eb = (exp_q[0].res >> ((TXB - 1 - mon_idx) * LANE)) & ((64'd1 << LANE) - 1);
        check($sformatf("beat%0d", mon_idx), 32'(miso), 32'(eb));
        check("carry", 32'(carry_out), 32'(exp_q[0].c));
        mon_idx++;
      end else begin
        check("pop_miso", 32'(miso), 0);
        void'(exp_q.pop_front());
        mon_idx = 0;
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

  initial begin
    int op, sel;
    do_reset();
    // Directed cases.
    send_frame(0, 200, 0, 100, 0); read_result();
    send_frame(1, 5, 0, 9, 0);     read_result();
    send_frame(3, 255, 255, 255, 255); read_result();
    send_frame(5, 0, 0, 0, 0);
    send_frame(4, 3, 0, 4, 0);
    send_frame(4, 3, 0, 4, 0);
    read_result(); read_result(); read_result();
    send_frame(9, 17, 1, 2, 3);
    send_frame(4, 0, 0, 0, 0);
    read_result(); read_result();
    // Overflow: fifth frame dropped, queue drains in order.
    do_reset();
    for (int i = 0; i < 5; i++) send_frame(0, 10 * i + 1, 0, i, 0);
    for (int i = 0; i < 4; i++) read_result();
    // Reset mid-frame, then a clean frame.
    do_reset();
    for (int i = 0; i < 6; i++) beat(1'b1, 1'b0, 4'hA);
    do_reset();
    send_frame(2, 7, 0, 6, 0); read_result();
    // Reset mid-send.
    send_frame(0, 255, 0, 255, 0);
    beat(1'b0, 1'b1, '0);
    beat(1'b0, 1'b1, '0);
    do_reset();
    read_result();
    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) != 0) begin
        sel = $urandom_range(0, 9);
        op = (sel <= 5) ? sel : $urandom_range(6, 15);
        op = op | ($urandom_range(0, 15) << 4);
        if ($urandom_range(0, 3) == 0)
          send_frame(op, 255, 255, 255, 255);
        else
          send_frame(op, $urandom_range(0, 255), $urandom_range(0, 255),
                     $urandom_range(0, 255), $urandom_range(0, 255));
      end else begin
        read_result();
      end
    end
    while (exp_q.size() > 0) read_result();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
